// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler -- round-robin arbiter that hands one shared sprite serializer to NUM_REQ requesters.
// Latency: req sampled in IDLE cycle N -> grant/ser_* N+1, ser_enable N+2..N+1+PIX_PER_SPRITE, done N+2+PIX_PER_SPRITE.
// Backpressure: requests are level-held; a requester waits (req high) until granted, no request is ever dropped.
//
// Ports:
//   clock, reset (synchronous, active-low), vblank (display blanking indicator)
//   req/req_x/req_y/req_color/req_sprite : packed per-requester draw requests (slice i belongs to requester i)
//   grant  : one-hot serializer owner during LOAD and DRAW, zero otherwise
//   done   : one-cycle pulse on the finishing requester's bit
//   ser_x/ser_y/ser_color/ser_sprite : latched draw parameters, held until the next LOAD
//   ser_enable : serializer read enable, high for PIX_PER_SPRITE consecutive cycles
//   busy   : high whenever the scheduler is not idle
//
// Build option: define SPRITE_SCHED_VBLANK_GATE_EN to start new draws only while vblank is high;
// without it vblank is ignored.
module sprite_draw_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int PIX_PER_SPRITE = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     vblank,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [10*NUM_REQ-1:0]    req_x,
  input  logic [10*NUM_REQ-1:0]    req_y,
  input  logic [8*NUM_REQ-1:0]     req_color,
  input  logic [256*NUM_REQ-1:0]   req_sprite,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [9:0]               ser_x,
  output logic [9:0]               ser_y,
  output logic [7:0]               ser_color,
  output logic [255:0]             ser_sprite,
  output logic                     ser_enable,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One bit wider than needed for 0..PIX_PER_SPRITE-1 so the count can never alias back to 0.
  localparam int CNT_W = $clog2(PIX_PER_SPRITE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         ser_x_q, ser_x_d;
  logic [9:0]         ser_y_q, ser_y_d;
  logic [7:0]         ser_color_q, ser_color_d;
  logic [255:0]       ser_sprite_q, ser_sprite_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [IDX_W-1:0]   cand;
  logic               gate_open;
  logic [NUM_REQ-1:0] owner;

`ifdef SPRITE_SCHED_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_open     = 1'b1;
`endif

  // Round-robin search: first requester found scanning from ptr+1 upward, wrapping at NUM_REQ.
  // The previous winner (ptr) is visited last, which gives the fairness guarantee.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    ser_x_d      = ser_x_q;
    ser_y_d      = ser_y_q;
    ser_color_d  = ser_color_q;
    ser_sprite_d = ser_sprite_q;
    case (state_q)
      IDLE: begin
        if (pick_vld && gate_open) begin
          state_d      = LOAD;
          winner_d     = pick;
          ser_x_d      = req_x[int'(pick)*10 +: 10];
          ser_y_d      = req_y[int'(pick)*10 +: 10];
          ser_color_d  = req_color[int'(pick)*8 +: 8];
          ser_sprite_d = req_sprite[int'(pick)*256 +: 256];
        end
      end
      LOAD: begin
        state_d = DRAW;
        cnt_d   = '0;
      end
      DRAW: begin
        if (cnt_q == CNT_W'(PIX_PER_SPRITE - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = winner_q;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q        <= IDX_W'(NUM_REQ - 1);
      winner_q     <= '0;
      cnt_q        <= '0;
      ser_x_q      <= '0;
      ser_y_q      <= '0;
      ser_color_q  <= '0;
      ser_sprite_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      ser_x_q      <= ser_x_d;
      ser_y_q      <= ser_y_d;
      ser_color_q  <= ser_color_d;
      ser_sprite_q <= ser_sprite_d;
    end
  end

  // Outputs are decoded from the registered state, so reset clears them on the same edge.
  always_comb begin
    owner           = '0;
    owner[winner_q] = 1'b1;
  end

  assign grant      = (state_q == LOAD || state_q == DRAW) ? owner : '0;
  assign done       = (state_q == DONE) ? owner : '0;
  assign ser_enable = (state_q == DRAW);
  assign busy       = (state_q != IDLE);
  assign ser_x      = ser_x_q;
  assign ser_y      = ser_y_q;
  assign ser_color  = ser_color_q;
  assign ser_sprite = ser_sprite_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;
  localparam int N = 4;
  localparam int P = 256;

  logic             clock = 1'b0;
  logic             reset;
  logic             vblank;
  logic [N-1:0]     req;
  logic [10*N-1:0]  req_x;
  logic [10*N-1:0]  req_y;
  logic [8*N-1:0]   req_color;
  logic [256*N-1:0] req_sprite;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic [9:0]       ser_x;
  logic [9:0]       ser_y;
  logic [7:0]       ser_color;
  logic [255:0]     ser_sprite;
  logic             ser_enable;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  sprite_draw_scheduler #(.NUM_REQ(N), .PIX_PER_SPRITE(P)) dut (
    .clock(clock), .reset(reset), .vblank(vblank), .req(req),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .req_sprite(req_sprite),
    .grant(grant), .done(done), .ser_x(ser_x), .ser_y(ser_y),
    .ser_color(ser_color), .ser_sprite(ser_sprite),
    .ser_enable(ser_enable), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {grant, done, ser_enable, busy}, '0);
    check({name, "_ser"}, {ser_x, ser_y, ser_color, ser_sprite}, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick(); tick(); tick();
    check_all_zero("reset_state");
    reset = 1'b1;
  endtask

  function automatic logic [255:0] sprite_of(input logic [7:0] col, input int i, input logic [9:0] x);
    return {8{col, 8'(i), x[7:0], 8'hA5}};
  endfunction

  // Slot i gets data derived from the row so the winner's slice is distinguishable.
  task automatic load_slots(input logic [9:0] x, input logic [9:0] y, input logic [7:0] col);
    for (int i = 0; i < N; i++) begin
      req_x[10*i +: 10]       = x + 10'(i);
      req_y[10*i +: 10]       = y + 10'(i);
      req_color[8*i +: 8]     = col ^ 8'(i);
      req_sprite[256*i +: 256] = sprite_of(col ^ 8'(i), i, x + 10'(i));
    end
  endtask

  // Watches a draw from offset 2 onward; req is released once offset >= drop_at.
  task automatic watch_draw(input string name, input int drop_at, input logic [N-1:0] exp_g, input int vb_fall_at);
    int ena, first_ena, done_at;
    logic [N-1:0] done_val;
    ena = 0; first_ena = -1; done_at = -1; done_val = '0;
    for (int d = 2; d <= 320 && done_at < 0; d++) begin
      if (d - 1 >= drop_at) req = '0;
      if (d - 1 == vb_fall_at) vblank = 1'b0;
      tick();
      if (ser_enable) begin
        ena++;
        if (first_ena < 0) first_ena = d;
      end
      if (done !== '0) begin
        done_at  = d;
        done_val = done;
      end
    end
    check({name, "_ena_cycles"}, 512'(ena), 512'(P));
    check({name, "_ena_first"}, 512'(first_ena), 512'd2);
    check({name, "_done_at"}, 512'(done_at), 512'(P + 2));
    check({name, "_done_val"}, done_val, exp_g);
    req = '0;
    tick();
    check({name, "_idle_after"}, {grant, busy}, '0);
  endtask

  typedef struct {
    logic [N-1:0] rq;
    logic [9:0]   x;
    logic [9:0]   y;
    logic [7:0]   col;
    int           exp_idx;
    int           drop_at;
  } vec_t;

  vec_t tbl[8];

  // Reference model state for the randomized run.
  int           m_start;
  bit           m_active;
  int           m_w;
  int           m_ptr;
  logic [9:0]   ex_x, ex_y;
  logic [7:0]   ex_col;
  logic [255:0] ex_spr;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  initial begin
    vblank     = 1'b1;
    req        = '0;
    req_x      = '0;
    req_y      = '0;
    req_color  = '0;
    req_sprite = '0;
    reset      = 1'b0;

    // Table: applied back to back from reset, so the round-robin pointer carries across rows.
    tbl[0] = '{rq: 4'b0001, x: 10'd100, y: 10'd50,  col: 8'hE0, exp_idx: 0, drop_at: 1};
    tbl[1] = '{rq: 4'b1111, x: 10'd7,   y: 10'd9,   col: 8'h11, exp_idx: 1, drop_at: 1};
    tbl[2] = '{rq: 4'b1001, x: 10'd300, y: 10'd200, col: 8'h3C, exp_idx: 3, drop_at: 1};
    tbl[3] = '{rq: 4'b1001, x: 10'd0,   y: 10'd0,   col: 8'h00, exp_idx: 0, drop_at: 1};
    tbl[4] = '{rq: 4'b0010, x: 10'd55,  y: 10'd66,  col: 8'h77, exp_idx: 1, drop_at: 12};
    tbl[5] = '{rq: 4'b0110, x: 10'd512, y: 10'd256, col: 8'hFF, exp_idx: 2, drop_at: 1};
    tbl[6] = '{rq: 4'b1100, x: 10'd33,  y: 10'd44,  col: 8'h5A, exp_idx: 3, drop_at: 1};
    tbl[7] = '{rq: 4'b1111, x: 10'd639, y: 10'd479, col: 8'h81, exp_idx: 0, drop_at: 1};

    do_reset();
    for (int r = 0; r < 8; r++) begin
      logic [N-1:0] eg;
      int w;
      w  = tbl[r].exp_idx;
      eg = '0;
      eg[w] = 1'b1;
      load_slots(tbl[r].x, tbl[r].y, tbl[r].col);
      req = tbl[r].rq;
      tick();
      check($sformatf("row%0d_grant", r), grant, eg);
      check($sformatf("row%0d_ser_x", r), ser_x, tbl[r].x + 10'(w));
      check($sformatf("row%0d_ser_y", r), ser_y, tbl[r].y + 10'(w));
      check($sformatf("row%0d_ser_color", r), ser_color, tbl[r].col ^ 8'(w));
      check($sformatf("row%0d_ser_sprite", r), ser_sprite, sprite_of(tbl[r].col ^ 8'(w), w, tbl[r].x + 10'(w)));
      check($sformatf("row%0d_busy_ena", r), {busy, ser_enable}, 2'b10);
      watch_draw($sformatf("row%0d", r), tbl[r].drop_at, eg, -1);
    end

    // Round robin with all requests held: grants rotate, 259 cycles apart.
    begin
      int t_g[$];
      logic [N-1:0] v_g[$];
      logic [N-1:0] prev, exp_seq;
      do_reset();
      load_slots(10'd1, 10'd2, 8'h03);
      req  = 4'b1111;
      prev = '0;
      for (int c = 1; c <= 5 * 259 + 20 && v_g.size() < 5; c++) begin
        tick();
        if (prev == '0 && grant != '0) begin
          t_g.push_back(c);
          v_g.push_back(grant);
        end
        prev = grant;
      end
      req = '0;
      check("rr_grant_count", 512'(v_g.size()), 512'd5);
      exp_seq = 4'b0001;
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_grant%0d", k), (k < v_g.size()) ? v_g[k] : '0, exp_seq);
        if (k > 0)
          check($sformatf("rr_spacing%0d", k), (k < t_g.size()) ? 512'(t_g[k] - t_g[k-1]) : '0, 512'd259);
        exp_seq = (exp_seq == 4'b1000) ? 4'b0001 : (exp_seq << 1);
      end
      for (int k = 0; k < 300 && busy; k++) tick();
      check("rr_drained", busy, 1'b0);
    end

    // Reset in the middle of a draw aborts it with no done; pointer returns to its reset value.
    begin
      logic [N-1:0] any_done;
      do_reset();
      load_slots(10'd400, 10'd300, 8'h42);
      req = 4'b0010;
      tick();
      req = '0;
      for (int d = 2; d <= 102; d++) tick();
      check("abort_in_draw", {busy, ser_enable}, 2'b11);
      reset = 1'b0;
      tick();
      check_all_zero("abort_reset");
      reset = 1'b1;
      any_done = '0;
      for (int k = 0; k < 300; k++) begin
        tick();
        any_done |= done;
      end
      check("abort_no_done", {any_done, busy}, '0);
      req = 4'b1001;
      tick();
      check("abort_then_grant0", grant, 4'b0001);
      req = '0;
      watch_draw("abort_next", 1, 4'b0001, -1);
    end

`ifdef SPRITE_SCHED_VBLANK_GATE_EN
    // Draws may only start in vblank, but one already running finishes after vblank falls.
    begin
      logic any_busy;
      do_reset();
      vblank = 1'b0;
      load_slots(10'd20, 10'd30, 8'h99);
      req = 4'b0001;
      any_busy = 1'b0;
      for (int k = 0; k < 20; k++) begin
        tick();
        any_busy |= busy;
      end
      check("vb_gate_closed", any_busy, 1'b0);
      vblank = 1'b1;
      tick();
      check("vb_grant", grant, 4'b0001);
      watch_draw("vb_draw", 1, 4'b0001, 50);
      vblank = 1'b1;
    end
`endif

    // Randomized run against a timeline model of each draw.
    do_reset();
    m_active = 1'b0;
    m_ptr    = N - 1;
    m_start  = 0;
    m_w      = 0;
    ex_x = '0; ex_y = '0; ex_col = '0; ex_spr = '0;
    req = '0;
    for (int c = 0; c < 5000; c++) begin
      bit gate;
      int d;
      logic [N-1:0] oh, e_grant, e_done;
      logic e_ena, e_busy;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
        req_x[10*i +: 10] = 10'($urandom());
        req_y[10*i +: 10] = 10'($urandom());
        req_color[8*i +: 8] = 8'($urandom());
      end
      for (int j = 0; j < 8 * N; j++) req_sprite[32*j +: 32] = $urandom();
      vblank = ($urandom_range(0, 3) != 0);
`ifdef SPRITE_SCHED_VBLANK_GATE_EN
      gate = vblank;
`else
      gate = 1'b1;
`endif
      if ((!m_active || c >= m_start + P + 3) && gate && req != '0) begin
        m_w      = rr_pick(req, m_ptr);
        m_ptr    = m_w;
        m_active = 1'b1;
        m_start  = c;
        ex_x     = req_x[10*m_w +: 10];
        ex_y     = req_y[10*m_w +: 10];
        ex_col   = req_color[8*m_w +: 8];
        ex_spr   = req_sprite[256*m_w +: 256];
      end
      tick();
      d  = c + 1 - m_start;
      oh = '0;
      oh[m_w] = 1'b1;
      e_grant = (m_active && d >= 1 && d <= P + 1) ? oh : '0;
      e_done  = (m_active && d == P + 2) ? oh : '0;
      e_ena   = m_active && d >= 2 && d <= P + 1;
      e_busy  = m_active && d >= 1 && d <= P + 2;
      check($sformatf("rand_ctl_c%0d", c), {grant, done, ser_enable, busy}, {e_grant, e_done, e_ena, e_busy});
      check($sformatf("rand_ser_c%0d", c), {ser_x, ser_y, ser_color, ser_sprite}, {ex_x, ex_y, ex_col, ex_spr});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
